// File: rtl/seq_match_pkg.sv
// ============================================================================
//  Module      : seq_match_pkg
//  Description : Shared constants, step-action encoding and pattern symbol
//                extraction for the seq_match_fsm sequence detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_match_pkg;

  // Index values used when the matcher restarts
  localparam int IDX_RESET       = 0;
  localparam int IDX_AFTER_FIRST = 1;

  // Upper bounds for the generic extraction function; patterns up to
  // MAX_PAT_W bits and symbols up to MAX_SYM_W bits are supported.
  localparam int MAX_PAT_W = 1024;
  localparam int MAX_SYM_W = 32;

  // What the matcher does on a given cycle
  typedef enum logic [2:0] {
    ACT_HOLD    = 3'd0,
    ACT_LOAD    = 3'd1,
    ACT_ADVANCE = 3'd2,
    ACT_ACCEPT  = 3'd3,
    ACT_RESTART = 3'd4
  } step_act_t;

  // Symbol k of a packed pattern (symbol 0 in the least significant bits).
  // Callers zero-extend their pattern and truncate the result to their width.
  function automatic logic [MAX_SYM_W-1:0] pattern_sym(
    input logic [MAX_PAT_W-1:0] pat,
    input int                   k,
    input int                   sym_w
  );
    return MAX_SYM_W'(pat >> (k * sym_w));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up counter that sticks at all-ones. Asynchronous
//                active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count increments, holding once every bit is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/seq_match_fsm.sv
// ============================================================================
//  Module      : seq_match_fsm
//  Description : Programmable DEPTH-symbol sequence detector over a
//                valid-qualified SYM_W-bit stream, with optional overlap and
//                a saturating match counter.
//                Build option: define SEQ_MATCH_CNT_EN to include the match
//                counter; without it match_cnt is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_match_fsm
  import seq_match_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [SYM_W-1:0]         in_sym,
  input  logic                     cfg_load,
  input  logic [DEPTH*SYM_W-1:0]   cfg_pattern,
  input  logic                     cfg_overlap,
  output logic                     out_match,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [$clog2(DEPTH)-1:0] state
);

  localparam int             c_idx_w    = $clog2(DEPTH);
  localparam [c_idx_w-1:0]   c_idx_last = c_idx_w'(DEPTH - 1);
  localparam [c_idx_w-1:0]   c_idx_rst  = c_idx_w'(IDX_RESET);
  localparam [c_idx_w-1:0]   c_idx_one  = c_idx_w'(IDX_AFTER_FIRST);

  logic [DEPTH*SYM_W-1:0] r_pat;
  logic                   r_ovl;
  logic [c_idx_w-1:0]     r_idx;
  logic                   r_match;

  logic [SYM_W-1:0]       w_sym_cur;
  logic [SYM_W-1:0]       w_sym_first;
  logic                   w_hit;
  logic                   w_is_first;
  step_act_t              w_act;
  logic [c_idx_w-1:0]     w_idx_nxt;
  logic                   w_match_nxt;

  // The symbol expected next and the pattern's first symbol
  assign w_sym_cur   = SYM_W'(pattern_sym(MAX_PAT_W'(r_pat), int'(r_idx), SYM_W));
  assign w_sym_first = SYM_W'(pattern_sym(MAX_PAT_W'(r_pat), 0, SYM_W));
  assign w_hit       = (in_sym == w_sym_cur);
  assign w_is_first  = (in_sym == w_sym_first);

  // Next-index and match-pulse decision; cfg_load wins over the stream
  always_comb begin
    w_act       = ACT_HOLD;
    w_idx_nxt   = r_idx;
    w_match_nxt = 1'b0;
    if (cfg_load) begin
      w_act     = ACT_LOAD;
      w_idx_nxt = c_idx_rst;
    end else if (in_valid) begin
      if (w_hit && (r_idx == c_idx_last)) begin
        w_act       = ACT_ACCEPT;
        w_match_nxt = 1'b1;
        w_idx_nxt   = (r_ovl && w_is_first) ? c_idx_one : c_idx_rst;
      end else if (w_hit) begin
        w_act     = ACT_ADVANCE;
        w_idx_nxt = r_idx + c_idx_w'(1);
      end else begin
        // Single-symbol restart: only the current symbol is reconsidered
        w_act     = ACT_RESTART;
        w_idx_nxt = w_is_first ? c_idx_one : c_idx_rst;
      end
    end
  end

  // State, configuration and registered match pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat   <= '0;
      r_ovl   <= 1'b0;
      r_idx   <= c_idx_rst;
      r_match <= 1'b0;
    end else begin
      if (w_act == ACT_LOAD) begin
        r_pat <= cfg_pattern;
        r_ovl <= cfg_overlap;
      end
      r_idx   <= w_idx_nxt;
      r_match <= w_match_nxt;
    end
  end

  assign out_match = r_match;
  assign state     = r_idx;

`ifdef SEQ_MATCH_CNT_EN
  sat_counter #(
    .W   (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_act == ACT_ACCEPT),
    .cnt (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_match_fsm.sv
// ============================================================================
//  Module      : tb_seq_match_fsm
//  Description : Self-checking bench for seq_match_fsm (SYM_W=2, DEPTH=4) with
//                an 8-bit counter instance and a 2-bit saturation instance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_match_fsm;

`ifdef SEQ_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_sym = 2'd0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = 8'd0;
  logic       cfg_overlap = 1'b0;

  logic       out_match, out_match_s;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt_s;
  logic [1:0] state, state_s;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: pattern as integers, progress as a plain count
  int m_pat[4];
  bit m_ovl;
  int m_p;
  bit m_match;
  int m_cnt8, m_cnt2;

  seq_match_fsm #(.SYM_W(2), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .out_match(out_match), .match_cnt(match_cnt), .state(state)
  );

  seq_match_fsm #(.SYM_W(2), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .out_match(out_match_s), .match_cnt(match_cnt_s), .state(state_s)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pack4(input int a, input int b, input int c, input int d);
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  function automatic int exp_cnt(input int c);
    return CNT_EN ? c : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_pat[k] = 0;
    m_ovl = 0; m_p = 0; m_match = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  task automatic model_step();
    int s;
    s = int'(in_sym);
    m_match = 0;
    if (cfg_load) begin
      for (int k = 0; k < 4; k++) m_pat[k] = int'((cfg_pattern >> (2 * k)) & 8'h3);
      m_ovl = cfg_overlap;
      m_p   = 0;
    end else if (in_valid) begin
      if (m_p == 3 && s == m_pat[3]) begin
        m_match = 1;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
        m_p = (m_ovl && s == m_pat[0]) ? 1 : 0;
      end else if (s == m_pat[m_p]) begin
        m_p++;
      end else begin
        m_p = (s == m_pat[0]) ? 1 : 0;
      end
    end
  endtask

  // Drive one cycle of inputs, let the model take the same edge, settle
  task automatic cycle(input bit v, input int sym, input bit load, input logic [7:0] pat, input bit ovl);
    @(negedge clk);
    in_valid = v; in_sym = 2'(sym); cfg_load = load; cfg_pattern = pat; cfg_overlap = ovl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; cfg_load = 0; rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (out_match !== 1'b0) begin n_fail++; $display("FAIL reset_match got %0b want 0", out_match); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", match_cnt); end
    n_cmp++; if (match_cnt_s !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_sat got %0d want 0", match_cnt_s); end
  endtask

  task automatic run_stream(input string name, input bit ovl, input int want_pulses, input int want_cnt, input int want_state);
    int stream[7] = '{1, 2, 3, 1, 2, 3, 1};
    int pulses = 0;
    do_reset();
    cycle(0, 0, 1, pack4(1, 2, 3, 1), ovl);
    for (int i = 0; i < 7; i++) begin
      cycle(1, stream[i], 0, cfg_pattern, ovl);
      if (out_match === 1'b1) pulses++;
      n_cmp++; if (out_match !== m_match || state !== 2'(m_p)) begin
        n_fail++; $display("FAIL %s_sym%0d got match=%0b state=%0d want match=%0b state=%0d",
                           name, i + 1, out_match, state, m_match, m_p);
      end
    end
    n_cmp++; if (pulses != want_pulses) begin n_fail++; $display("FAIL %s_pulses got %0d want %0d", name, pulses, want_pulses); end
    n_cmp++; if (match_cnt !== 8'(exp_cnt(want_cnt))) begin n_fail++; $display("FAIL %s_cnt got %0d want %0d", name, match_cnt, exp_cnt(want_cnt)); end
    n_cmp++; if (state !== 2'(want_state)) begin n_fail++; $display("FAIL %s_final_state got %0d want %0d", name, state, want_state); end
  endtask

  task automatic test_overlap();
    run_stream("overlap", 1'b1, 2, 2, 1);
  endtask

  task automatic test_non_overlap();
    run_stream("non_overlap", 1'b0, 1, 1, 1);
  endtask

  task automatic test_restart();
    int stream[5] = '{1, 1, 2, 3, 1};
    int want_st[5] = '{1, 1, 2, 3, 0};
    do_reset();
    cycle(0, 0, 1, pack4(1, 2, 3, 1), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, stream[i], 0, cfg_pattern, 1'b0);
      n_cmp++; if (state !== 2'(want_st[i]) || out_match !== (i == 4)) begin
        n_fail++; $display("FAIL restart_sym%0d got state=%0d match=%0b want state=%0d match=%0b",
                           i + 1, state, out_match, want_st[i], (i == 4));
      end
    end
  endtask

  task automatic test_gap_collision();
    do_reset();
    cycle(0, 0, 1, pack4(1, 2, 3, 1), 1'b0);
    cycle(1, 1, 0, cfg_pattern, 1'b0);
    cycle(1, 2, 0, cfg_pattern, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, $urandom_range(0, 3), 0, cfg_pattern, 1'b0);
      n_cmp++; if (state !== 2'd2 || out_match !== 1'b0) begin
        n_fail++; $display("FAIL gap_hold%0d got state=%0d match=%0b want state=2 match=0", i, state, out_match);
      end
    end
    cycle(1, 3, 0, cfg_pattern, 1'b0);
    cycle(1, 1, 0, cfg_pattern, 1'b0);
    n_cmp++; if (out_match !== 1'b1) begin n_fail++; $display("FAIL gap_match got %0b want 1", out_match); end
    cycle(1, 1, 0, cfg_pattern, 1'b0);
    cycle(1, 1, 1, pack4(1, 2, 3, 1), 1'b0);
    n_cmp++; if (state !== 2'd0 || out_match !== 1'b0) begin
      n_fail++; $display("FAIL load_collision got state=%0d match=%0b want state=0 match=0", state, out_match);
    end
    cycle(1, 2, 0, cfg_pattern, 1'b0);
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL load_dropped got state=%0d want 0", state); end
  endtask

  task automatic test_saturation();
    int seq[4] = '{1, 2, 3, 1};
    int want[5] = '{1, 2, 3, 3, 3};
    do_reset();
    cycle(0, 0, 1, pack4(1, 2, 3, 1), 1'b0);
    for (int m = 0; m < 5; m++) begin
      for (int i = 0; i < 4; i++) cycle(1, seq[i], 0, cfg_pattern, 1'b0);
      n_cmp++; if (out_match_s !== 1'b1 || match_cnt_s !== 2'(exp_cnt(want[m]))) begin
        n_fail++; $display("FAIL saturate_m%0d got match=%0b cnt=%0d want match=1 cnt=%0d",
                           m + 1, out_match_s, match_cnt_s, exp_cnt(want[m]));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(0, 0, 1, pack4(1, 2, 3, 1), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1, (i == 0 || i == 3) ? 1 : i + 1, 0, cfg_pattern, 1'b0);
    cycle(1, 1, 0, cfg_pattern, 1'b0);
    cycle(1, 2, 0, cfg_pattern, 1'b0);
    cycle(1, 3, 0, cfg_pattern, 1'b0);
    // Mid-cycle assertion: outputs must clear without waiting for an edge
    #2;
    rst = 1;
    model_reset();
    #1;
    n_cmp++; if (state !== 2'd0 || out_match !== 1'b0 || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL async_reset got state=%0d match=%0b cnt=%0d want 0/0/0", state, out_match, match_cnt);
    end
    @(negedge clk);
    rst = 0;
    cycle(0, 0, 1, pack4(1, 2, 3, 1), 1'b0);
    cycle(1, 1, 0, cfg_pattern, 1'b0);
    n_cmp++; if (state !== 2'd1 || out_match !== 1'b0) begin
      n_fail++; $display("FAIL after_reset got state=%0d match=%0b want 1/0", state, out_match);
    end
    // Reset landing while a match pulse is high
    cycle(1, 2, 0, cfg_pattern, 1'b0);
    cycle(1, 3, 0, cfg_pattern, 1'b0);
    cycle(1, 1, 0, cfg_pattern, 1'b0);
    #2;
    rst = 1;
    model_reset();
    #1;
    n_cmp++; if (out_match !== 1'b0 || match_cnt_s !== 2'd0) begin
      n_fail++; $display("FAIL async_reset_pulse got match=%0b cnt=%0d want 0/0", out_match, match_cnt_s);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_random();
    bit   v, ld, ov;
    int   sym;
    logic [7:0] pat;
    do_reset();
    cycle(0, 0, 1, pack4(1, 2, 3, 1), 1'b1);
    for (int n = 0; n < 600; n++) begin
      ld  = ($urandom_range(0, 49) == 0);
      pat = ld ? 8'($urandom) : cfg_pattern;
      ov  = ld ? 1'($urandom) : cfg_overlap;
      v   = ($urandom_range(0, 7) != 0);
      sym = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : m_pat[m_p];
      cycle(v, sym, ld, pat, ov);
      n_cmp++; if (out_match !== m_match) begin n_fail++; $display("FAIL rand_match@%0d got %0b want %0b", n, out_match, m_match); end
      n_cmp++; if (state !== 2'(m_p)) begin n_fail++; $display("FAIL rand_state@%0d got %0d want %0d", n, state, m_p); end
      n_cmp++; if (match_cnt !== 8'(exp_cnt(m_cnt8))) begin n_fail++; $display("FAIL rand_cnt@%0d got %0d want %0d", n, match_cnt, exp_cnt(m_cnt8)); end
      n_cmp++; if (match_cnt_s !== 2'(exp_cnt(m_cnt2))) begin n_fail++; $display("FAIL rand_cnt_sat@%0d got %0d want %0d", n, match_cnt_s, exp_cnt(m_cnt2)); end
    end
  endtask

  initial begin
    model_reset();
    rst = 1;
    #12;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_restart();
    test_gap_collision();
    test_saturation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_match_fsm.md
# seq_match_fsm

Parametrised sequence-detector state machine that watches a valid-qualified stream of SYM_W-bit symbols for a programmable DEPTH-symbol pattern. It is the generalised successor to the fixed 2-bit, four-state machines in the codebase, with configurable symbol width, pattern depth, overlap mode and a saturating match counter. It sits between an input symbol source and downstream logic that consumes the match pulse and the count.

## Interface
- SYM_W, 2, symbol width in bits (≥1)
- DEPTH, 4, pattern length in symbols (≥2)
- CNT_W, 8, match counter width (≥1)

- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_sym is sampled this cycle
- in_sym  input  SYM_W  stream symbol
- cfg_load  input  1  latch cfg_pattern/cfg_overlap; clear match progress
- cfg_pattern  input  DEPTH*SYM_W  pattern; symbol k at bits [k*SYM_W +: SYM_W]; symbol 0 is matched first
- cfg_overlap  input  1  1 = overlapping matches allowed
- out_match  output  1  registered one-cycle match pulse
- match_cnt  output  CNT_W  saturating count of matches
- state  output  $clog2(DEPTH)  current index (symbols matched so far, 0..DEPTH-1)

## Operation
- Registers: pat (DEPTH*SYM_W), ovl (1), idx (state), out_match, match_cnt.
- Priority, each cycle: rst > cfg_load > in_valid > hold.
- cfg_load=1: pat←cfg_pattern, ovl←cfg_overlap, idx←0, out_match←0; in_sym is dropped even if in_valid=1; match_cnt is unchanged.
- in_valid=0: idx and match_cnt hold; out_match←0.
- in_valid=1, in_sym == pat[idx], idx < DEPTH-1: idx←idx+1.
- in_valid=1, in_sym == pat[DEPTH-1], idx == DEPTH-1 (accept):
  - out_match←1; match_cnt←match_cnt+1, saturating at 2^CNT_W-1.
  - idx←(ovl && in_sym == pat[0]) ? 1 : 0.
- in_valid=1, mismatch: idx←(in_sym == pat[0]) ? 1 : 0. This is a single-symbol restart rule, not full prefix-function fallback, and is the required behaviour.
- All comparisons are exact over SYM_W bits. No X-propagation handling is required beyond reset.

## Timing
- Reset values: idx=0, pat=0, ovl=0, out_match=0, match_cnt=0. Assertion is asynchronous; release is synchronous to clk.
- Reset mid-sequence discards partial progress. The first valid symbol after release is compared against pat[0].
- out_match is high for exactly the one cycle after the clock edge that samples the accepting symbol. Latency is 1.
- Back-to-back accepts (overlap, DEPTH consecutive symbols ending each match) produce out_match high on consecutive accept cycles only. There is no combinational path from in_sym to out_match.
- match_cnt updates on the same edge out_match rises. At saturation it holds, and out_match still pulses.
- state reflects idx after each edge.

## Configuration
- SEQ_MATCH_CNT_EN defined: match_cnt counter is present as specified.
- SEQ_MATCH_CNT_EN undefined: counter logic is removed and match_cnt is tied to 0. out_match and all FSM behaviour are unchanged.

## Structure
- Package seq_match_pkg holds:
  - the restart-index constants (IDX_RESET=0, IDX_AFTER_FIRST=1)
  - a function extracting symbol k from a packed pattern
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output cnt) implements the saturating counter. It is instantiated only under SEQ_MATCH_CNT_EN.

## Test plan
All scenarios use SYM_W=2, DEPTH=4, CNT_W=8, and cfg_pattern symbols 1,2,3,1 loaded via cfg_load.
- Overlap: ovl=1, stream 1,2,3,1,2,3,1 → out_match pulses after symbols 4 and 7; match_cnt=2; final state=1.
- Non-overlap: ovl=0, same stream → single pulse after symbol 4; match_cnt=1; final state=1.
- Restart rule: stream 1,1,2,3,1 → state sequence 1,1,2,3,then accept; one pulse after symbol 5.
- Gaps and cfg_load collision: in_valid low for 3 cycles mid-pattern → state holds and a match still occurs. cfg_load with in_valid=1 and in_sym=1 → state=0 next cycle and that symbol is dropped.
- Saturation: CNT_W=2, five matches → match_cnt reads 1,2,3,3,3 and out_match pulses all five times.
- Async reset: assert rst between clock edges after symbols 1,2,3 → state, out_match and match_cnt go to 0 immediately. Following symbol 1 → state=1, no pulse.
